// File: rtl/irr_sync_param.sv
// rtl/irr_sync_param.sv - parametrised interrupt request register with sync, edge/level latch, rotating priority
module irr_sync_param #(
    parameter int NUM_IR      = 8,
    parameter int SYNC_STAGES = 2,
    localparam int ID_W       = $clog2(NUM_IR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IR-1:0] ir,
    input  logic [NUM_IR-1:0] ltim,
    input  logic [NUM_IR-1:0] imr,
    input  logic              clear,
    input  logic [NUM_IR-1:0] clear_sel,
    input  logic [ID_W-1:0]   prio_base,
    input  logic              overrun_clr,
    output logic [NUM_IR-1:0] irr,
    output logic              int_req,
    output logic [NUM_IR-1:0] highest_onehot,
    output logic [ID_W-1:0]   highest_id,
    output logic [NUM_IR-1:0] overrun
);

    logic [NUM_IR-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IR-1:0] ir_s;
    logic [NUM_IR-1:0] ir_d;
    logic [NUM_IR-1:0] rise;
    logic [NUM_IR-1:0] pend;
    logic [NUM_IR-1:0] pend_next;
    logic [NUM_IR-1:0] edge_set;
    logic [NUM_IR-1:0] clr_hit;
    logic [NUM_IR-1:0] vis_next;
    logic [NUM_IR-1:0] ovr_set;
    logic [NUM_IR-1:0] hot_next;
    logic [ID_W-1:0]   id_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= ir;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign ir_s     = sync_q[SYNC_STAGES-1];
    assign rise     = ir_s & ~ir_d;
    assign edge_set = rise & ~imr;
    assign clr_hit  = clear_sel & {NUM_IR{clear}};

    // Edge channels: a new request beats a coincident clear; level channels follow the line.
    assign pend_next = (ltim & ir_s) | (~ltim & (edge_set | (pend & ~clr_hit)));
    assign vis_next  = pend_next & ~imr;
    assign ovr_set   = ~ltim & edge_set & pend & ~clr_hit;

    always_comb begin
        int base;
        int idx;
        logic found;
        logic [ID_W-1:0] pick;
        hot_next = '0;
        id_next  = '0;
        found    = 1'b0;
        base     = int'(prio_base) % NUM_IR;
        for (int k = 0; k < NUM_IR; k++) begin
            idx  = (base + k) % NUM_IR;
            pick = ID_W'(idx);
            if (!found && vis_next[pick]) begin
                found          = 1'b1;
                hot_next[pick] = 1'b1;
                id_next        = pick;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_d           <= '0;
            pend           <= '0;
            irr            <= '0;
            int_req        <= 1'b0;
            highest_onehot <= '0;
            highest_id     <= '0;
            overrun        <= '0;
        end else begin
            ir_d           <= ir_s;
            pend           <= pend_next;
            irr            <= vis_next;
            int_req        <= |vis_next;
            highest_onehot <= hot_next;
            highest_id     <= id_next;
            overrun        <= ovr_set | (overrun & ~{NUM_IR{overrun_clr}});
        end
    end

endmodule

// File: tb/tb_irr_sync_param.sv
// tb/tb_irr_sync_param.sv - directed self-checking bench for irr_sync_param
module tb_irr_sync_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ir, ltim, imr, clear_sel;
    logic       clear, overrun_clr;
    logic [2:0] prio_base;
    logic [7:0] irr, highest_onehot, overrun;
    logic       int_req;
    logic [2:0] highest_id;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    irr_sync_param #(.NUM_IR(8), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .ir             (ir),
        .ltim           (ltim),
        .imr            (imr),
        .clear          (clear),
        .clear_sel      (clear_sel),
        .prio_base      (prio_base),
        .overrun_clr    (overrun_clr),
        .irr            (irr),
        .int_req        (int_req),
        .highest_onehot (highest_onehot),
        .highest_id     (highest_id),
        .overrun        (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_irr, input logic [2:0] e_id,
                             input logic [7:0] e_ovr);
        logic [7:0] e_hot;
        e_hot = (e_irr == 8'h00) ? 8'h00 : (8'h01 << e_id);
        check({tag, ".irr"}, 32'(irr), 32'(e_irr));
        check({tag, ".int_req"}, 32'(int_req), 32'(e_irr != 8'h00));
        check({tag, ".id"}, 32'(highest_id), 32'(e_id));
        check({tag, ".onehot"}, 32'(highest_onehot), 32'(e_hot));
        check({tag, ".overrun"}, 32'(overrun), 32'(e_ovr));
    endtask

    initial begin
        reset = 1'b1; ir = '0; ltim = '0; imr = '0; clear = 1'b0; clear_sel = '0;
        prio_base = '0; overrun_clr = 1'b0;
        step(2);
        check_all("reset", 8'h00, 3'd0, 8'h00);
        reset = 1'b0;
        step(1);

        // single edge on ch3, latency and stickiness
        ir = 8'h08;
        step(2);
        check("t1.early", 32'(irr), 32'h00);
        step(1);
        check_all("t1.latched", 8'h08, 3'd3, 8'h00);
        ir = 8'h00;
        step(4);
        check_all("t1.sticky", 8'h08, 3'd3, 8'h00);
        clear = 1'b1; clear_sel = 8'h08;
        step(1);
        clear = 1'b0; clear_sel = '0;
        check_all("t1.cleared", 8'h00, 3'd0, 8'h00);

        // rotating priority
        ir = 8'h24;
        step(3);
        check_all("t2.base0", 8'h24, 3'd2, 8'h00);
        prio_base = 3'd3;
        step(1);
        check_all("t2.base3", 8'h24, 3'd5, 8'h00);
        prio_base = 3'd6;
        step(1);
        check_all("t2.base6", 8'h24, 3'd2, 8'h00);
        prio_base = 3'd5;
        step(1);
        check_all("t2.base5", 8'h24, 3'd5, 8'h00);
        prio_base = 3'd0; ir = 8'h00;
        clear = 1'b1; clear_sel = 8'h24;
        step(1);
        clear = 1'b0; clear_sel = '0;
        check_all("t2.multiclr", 8'h00, 3'd0, 8'h00);

        // level-triggered ch1
        ltim = 8'h02; ir = 8'h02;
        step(3);
        check_all("t3.level", 8'h02, 3'd1, 8'h00);
        clear = 1'b1; clear_sel = 8'h02;
        step(1);
        clear = 1'b0; clear_sel = '0;
        check_all("t3.noclr", 8'h02, 3'd1, 8'h00);
        step(1);
        ir = 8'h00;
        step(2);
        check("t3.hold", 32'(irr), 32'h02);
        step(1);
        check_all("t3.drop", 8'h00, 3'd0, 8'h00);
        ltim = 8'h00;

        // masking
        imr = 8'h01; ir = 8'h01;
        step(3);
        check_all("t4.masked", 8'h00, 3'd0, 8'h00);
        ir = 8'h00; imr = 8'h00;
        step(3);
        check_all("t4.discarded", 8'h00, 3'd0, 8'h00);
        ir = 8'h10;
        step(3);
        check_all("t4.ch4", 8'h10, 3'd4, 8'h00);
        ir = 8'h00; imr = 8'h10;
        step(1);
        check_all("t4.hidden", 8'h00, 3'd0, 8'h00);
        imr = 8'h00;
        step(1);
        check_all("t4.revealed", 8'h10, 3'd4, 8'h00);
        clear = 1'b1; clear_sel = 8'h10;
        step(1);
        clear = 1'b0; clear_sel = '0;

        // overrun
        ir = 8'h40;
        step(3);
        check_all("t5.first", 8'h40, 3'd6, 8'h00);
        ir = 8'h00;
        step(2);
        ir = 8'h40;
        step(3);
        check_all("t5.overrun", 8'h40, 3'd6, 8'h40);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        check_all("t5.ovrclr", 8'h40, 3'd6, 8'h00);
        ir = 8'h00;
        step(2);
        ir = 8'h40;
        step(2);
        clear = 1'b1; clear_sel = 8'h40;
        step(1);
        clear = 1'b0; clear_sel = '0;
        check_all("t5.setwins", 8'h40, 3'd6, 8'h00);
        ir = 8'h00;
        step(2);
        ir = 8'h40;
        step(2);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        check_all("t5.ovrsetwins", 8'h40, 3'd6, 8'h40);

        // reset mid-operation and line held through reset
        ir = 8'hFF;
        step(3);
        check_all("t6.allset", 8'hFF, 3'd0, 8'h40);
        reset = 1'b1;
        step(1);
        check_all("t6.reset", 8'h00, 3'd0, 8'h00);
        step(1);
        reset = 1'b0;
        step(2);
        check("t6.wait", 32'(irr), 32'h00);
        step(1);
        check_all("t6.reedge", 8'hFF, 3'd0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
